// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between NUM_REQ adder clients and the shared-adder arbiter.
// Requests are packed per requester; the response carries sum, flags and owner id.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;
    logic                     rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing of one adder across NUM_REQ requesters; 1-cycle latency.
// A held response (rsp_valid & ~rsp_ready) blocks all grants; drain and accept may overlap.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus
);

    logic [ID_W-1:0]    r_ptr;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_sum;
    logic               r_rsp_carry;
    logic               r_rsp_overflow;

    logic               w_can_accept;
    logic               w_found;
    logic               w_xfer;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [WIDTH-1:0]   w_a_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_b_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_cin;
    logic [WIDTH:0]     w_sum_ext;
    logic               w_overflow;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_a_arr[g] = bus.req_a[g*WIDTH +: WIDTH];
        assign w_b_arr[g] = bus.req_b[g*WIDTH +: WIDTH];
    end

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req_valid[rr_idx(r_ptr, k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_can_accept = ~r_rsp_valid | bus.rsp_ready;
    assign w_xfer       = rst_n & w_can_accept & w_found;
    assign w_req_ready  = w_xfer ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_nxt    = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign w_a        = w_a_arr[w_gnt_idx];
    assign w_b        = w_b_arr[w_gnt_idx];
    assign w_cin      = bus.req_cin[w_gnt_idx];
    assign w_sum_ext  = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_overflow = ~(w_a[WIDTH-1] ^ w_b[WIDTH-1]) & (w_sum_ext[WIDTH-1] ^ w_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_sum      <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else if (w_xfer) begin
            r_ptr          <= w_ptr_nxt;
            r_rsp_valid    <= 1'b1;
            r_rsp_id       <= w_gnt_idx;
            r_rsp_sum      <= w_sum_ext[WIDTH-1:0];
            r_rsp_carry    <= w_sum_ext[WIDTH];
            r_rsp_overflow <= w_overflow;
        end else if (bus.rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_sum      = r_rsp_sum;
    assign bus.rsp_carry    = r_rsp_carry;
    assign bus.rsp_overflow = r_rsp_overflow;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized and directed checks of adder_share_arbiter against a transaction-level model.
module tb_adder_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bus ();

    adder_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks;
    int          n_errors;
    logic [31:0] op_a [NR];
    logic [31:0] op_b [NR];
    logic        op_c [NR];

    // Reference model state: the response register contents and the next-favoured requester.
    bit          m_valid;
    int          m_id;
    int          m_ptr;
    logic [31:0] m_sum;
    bit          m_carry;
    bit          m_ovf;
    logic [3:0]  last_rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_ptr = 0; m_sum = '0; m_carry = 0; m_ovf = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*W +: W] = op_a[i];
            bus.req_b[i*W +: W] = op_b[i];
            bus.req_cin[i]      = op_c[i];
        end
    endtask

    task automatic check_rsp();
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        check("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
        check("rsp_carry", 64'(bus.rsp_carry), 64'(m_carry));
        check("rsp_overflow", 64'(bus.rsp_overflow), 64'(m_ovf));
    endtask

    // One clock: check grant at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int               pick;
        logic [3:0]       exp_rdy;
        longint unsigned  s;
        @(negedge clk);
        exp_rdy = '0;
        pick    = -1;
        if (rst_n && (!m_valid || bus.rsp_ready)) begin
            pick = rr_pick(bus.req_valid, m_ptr);
            if (pick >= 0) exp_rdy[pick] = 1'b1;
        end
        last_rdy = bus.req_ready;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (pick >= 0) begin
            s       = 64'(op_a[pick]) + 64'(op_b[pick]) + 64'(op_c[pick]);
            m_valid = 1;
            m_id    = pick;
            m_sum   = s[31:0];
            m_carry = s[32];
            m_ovf   = (op_a[pick][31] == op_b[pick][31]) && (m_sum[31] != op_a[pick][31]);
            m_ptr   = (pick + 1) % NR;
        end else if (m_valid && bus.rsp_ready) begin
            m_valid = 0;
        end
        #1;
        check_rsp();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] e_a   [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] e_b   [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] e_sum [3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    logic        e_cy  [3] = '{1'b0, 1'b1, 1'b1};
    logic        e_ov  [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = 1'b0;
        end
        drive();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Requests pending during reset must never see req_ready.
        bus.req_valid = 4'hF;
        repeat (3) cycle();
        bus.req_valid = '0;
        rst_n = 1'b1;
        cycle();
        check("idle_rdy", 64'(last_rdy), 64'h0);
        check("idle_valid", 64'(bus.rsp_valid), 64'h0);
        check("idle_sum", 64'(bus.rsp_sum), 64'h0);

        op_a[2] = 32'h5; op_b[2] = 32'h3; op_c[2] = 1'b1;
        drive();
        bus.req_valid = 4'b0100;
        cycle();
        check("single_rdy", 64'(last_rdy), 64'b0100);
        check("single_id", 64'(bus.rsp_id), 64'd2);
        check("single_sum", 64'(bus.rsp_sum), 64'h9);
        check("single_flags", 64'({bus.rsp_carry, bus.rsp_overflow}), 64'b00);

        // Corner arithmetic through requester 3, which also wraps the pointer back to 0.
        bus.req_valid = 4'b1000;
        for (int t = 0; t < 3; t++) begin
            op_a[3] = e_a[t]; op_b[3] = e_b[t]; op_c[3] = 1'b0;
            drive();
            cycle();
            check("edge_sum", 64'(bus.rsp_sum), 64'(e_sum[t]));
            check("edge_carry", 64'(bus.rsp_carry), 64'(e_cy[t]));
            check("edge_ovf", 64'(bus.rsp_overflow), 64'(e_ov[t]));
        end

        bus.req_valid = 4'hF;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NR; i++) begin
                op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = 1'($urandom_range(0, 1));
            end
            drive();
            cycle();
            check("fair_id", 64'(bus.rsp_id), 64'(t % NR));
        end

        bus.req_valid = 4'b0011;
        cycle();
        bus.rsp_ready = 1'b0;
        repeat (4) begin
            cycle();
            check("bp_rdy", 64'(last_rdy), 64'h0);
            check("bp_id", 64'(bus.rsp_id), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("bp_release_rdy", 64'(last_rdy), 64'b0010);
        check("bp_release_id", 64'(bus.rsp_id), 64'd1);

        for (int t = 0; t < 400; t++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                op_a[i] = rand_operand(); op_b[i] = rand_operand();
                op_c[i] = 1'($urandom_range(0, 1));
            end
            drive();
            cycle();
        end

        // Reset arriving between edges while a response is stalled.
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 64'(bus.rsp_valid), 64'h0);
        check("async_rdy", 64'(bus.req_ready), 64'h0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        cycle();
        check("post_rst_rdy", 64'(last_rdy), 64'b0001);
        check("post_rst_id", 64'(bus.rsp_id), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
